jtframe_hsize_ctrl: RTL and testbench
=====================================

Name: jtframe_hsize_ctrl

Overview:
Configuration sequencer for the horizontal scaler. It takes raw scale/offset/enable requests from the OSD/status word, debounces them, and applies them only on a vertical-sync rising edge. With the slew feature built in, it moves the applied values one step per frame toward the target. It also measures the active line width so the OSD can display it. It sits between the status-bit decoder and the scaler's scale/offset/enable inputs.

Parameters:
SCREEN_WIDTH, 384, pixel width of a line including blanking; sets VW = 8/9/10 bits (≤256 / ≤512 / else).
HOLD_FRAMES, 2, number of VS edges a changed request must stay stable before it is applied (1..15).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pxl_cen  in  1  pixel clock enable; all video sampling is qualified by it
VS_in  in  1  vertical sync, active high
HS_in  in  1  horizontal sync, active high
HB_in  in  1  horizontal blank, active high
scale_req  in  4  requested scale code (8 = 1:1)
offset_req  in  5  requested offset, two's complement
enable_req  in  1  requested scaler enable
scale  out  4  applied scale code
offset  out  5  applied offset
enable  out  1  applied enable
busy  out  1  high while applied values differ from the accepted target
act_width  out  VW  active pixels per line, maximum over the previous frame

Behaviour:
- Reset (async, rst_n=0): scale=8, offset=0, enable=0, busy=0, act_width=0, hold counter=0, state=IDLE. Deassertion is honoured on any clock edge.
- Edge detect: VS and HS are registered on pxl_cen. vs_edge / hs_edge = rising edge, each one pxl_cen wide.
- Request register: {enable_req, scale_req, offset_req} is sampled every clk into req_l. Any difference between req_l and the current input clears the hold counter.
- States:
  - IDLE: when req_l ≠ {enable, scale, offset}, go to HOLD and set busy=1.
  - HOLD: the hold counter increments on each vs_edge. When it reaches HOLD_FRAMES, latch req_l as target and go to STEP. The counter is cleared on any request change.
  - STEP: on each vs_edge, update the applied values toward the target (see the Optional Feature). When applied equals target, return to IDLE and set busy=0 in the same cycle.
- Enable rules:
  - Enable 0→1: at the first STEP vs_edge, set enable=1 with scale=8 and offset=0; later edges step toward the target.
  - Enable 1→0: enable, scale and offset jump to 0/8/0 at the next vs_edge, regardless of slew.
- Request change during STEP: return to HOLD, freeze the applied values, clear the hold counter. No output glitch.
- Outputs change only on the clk cycle carrying vs_edge. They never change mid-frame.
- Offset arithmetic: signed 5-bit. A step is ±1 toward the target, with no wrap (−16..+15 stays in range). Scale steps ±1, unsigned, range 0..15.
- Width measurement:
  - Line counter (VW bits) counts pxl_cen cycles with HB_in=0, clears on hs_edge, saturates at SCREEN_WIDTH−1.
  - On hs_edge, a per-frame maximum register takes the larger of itself and the line count.
  - On vs_edge, act_width ← frame maximum and the maximum clears.
  - If hs_edge and vs_edge coincide, the finishing line is included in act_width.
- Latency: request stable → first applied change = HOLD_FRAMES+1 vs edges (+1 clk).

Optional Feature:
JTFRAME_HSIZE_SLEW_EN
- Defined: STEP moves scale and offset by at most 1 each per vs_edge (smooth zoom/pan). busy stays high across multiple frames.
- Undefined: STEP loads the target in full on the first vs_edge and returns to IDLE. The enable-on preload still applies, so enabling takes exactly two vs edges.

Test Plan:
- Reset: rst_n low mid-STEP with scale=11 → all outputs immediately 8/0/0, busy=0, act_width=0; no clock required.
- Enable: enable_req=1, scale_req=8, offset_req=0, HOLD_FRAMES=2 → enable=1 on the 3rd vs_edge, busy high from the cycle after the request until then.
- Slew on (JTFRAME_HSIZE_SLEW_EN): scale 8→12 while enabled → scale 9,10,11,12 on four successive vs edges after the hold; busy clears with 12. Without the macro: 12 on the first STEP edge.
- Offset: offset −3→+2 with slew → −2,−1,0,1,2. Toggle offset_req during HOLD every frame → outputs never change.
- Width: HB low for 320 pxl_cen per line, one line at 330 → act_width=330 after the next vs_edge. HB never asserted → act_width=SCREEN_WIDTH−1.
- Disable during STEP: enable_req=0 mid-slew → next vs_edge gives enable=0, scale=8, offset=0, busy=0.

Source files
------------

// File: rtl/jtframe_hsize_ctrl.sv
// rtl/jtframe_hsize_ctrl.sv - debounced, vsync-aligned horizontal scaler config sequencer with line width meter
// Optional feature macro: JTFRAME_HSIZE_SLEW_EN (step applied values one unit per frame)
module jtframe_hsize_ctrl #(
  parameter int SCREEN_WIDTH = 384,
  parameter int HOLD_FRAMES  = 2,
  localparam int VW = (SCREEN_WIDTH <= 256) ? 8 : (SCREEN_WIDTH <= 512) ? 9 : 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          VS_in,
  input  logic          HS_in,
  input  logic          HB_in,
  input  logic [3:0]    scale_req,
  input  logic [4:0]    offset_req,
  input  logic          enable_req,
  output logic [3:0]    scale,
  output logic [4:0]    offset,
  output logic          enable,
  output logic          busy,
  output logic [VW-1:0] act_width
);

  typedef struct packed {
    logic       en;
    logic [3:0] scale;
    logic [4:0] offset;
  } cfg_t;

  typedef enum logic [1:0] {IDLE, HOLD, STEP} state_t;

  localparam cfg_t          CFG_OFF   = '{en: 1'b0, scale: 4'd8, offset: 5'd0};
  localparam cfg_t          CFG_ON    = '{en: 1'b1, scale: 4'd8, offset: 5'd0};
  localparam logic [3:0]    HOLD_LAST = 4'(HOLD_FRAMES - 1);
  localparam logic [VW-1:0] LINE_MAX  = VW'(SCREEN_WIDTH - 1);

  state_t        state_q, state_d;
  cfg_t          req_q, req_d, app_q, app_d, tgt_q, tgt_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          vs_q, vs_d, hs_q, hs_d;
  logic [VW-1:0] line_q, line_d, fmax_q, fmax_d, width_q, width_d;

  cfg_t          req_now, req_n, step_cfg;
  logic          req_chg, vs_edge, hs_edge, force_off;
  logic [VW-1:0] line_best;

  // A disabled request means "scaler bypassed"; scale/offset are then irrelevant.
  function automatic cfg_t norm(input cfg_t c);
    return c.en ? c : CFG_OFF;
  endfunction

  function automatic cfg_t step_to(input cfg_t cur, input cfg_t tgt);
    cfg_t nxt;
    nxt = cur;
    if (!cur.en) begin
      nxt = CFG_ON;
    end else begin
`ifdef JTFRAME_HSIZE_SLEW_EN
      if (tgt.scale > cur.scale)      nxt.scale = cur.scale + 4'd1;
      else if (tgt.scale < cur.scale) nxt.scale = cur.scale - 4'd1;
      if ($signed(tgt.offset) > $signed(cur.offset))      nxt.offset = cur.offset + 5'd1;
      else if ($signed(tgt.offset) < $signed(cur.offset)) nxt.offset = cur.offset - 5'd1;
`else
      nxt = tgt;
`endif
    end
    return nxt;
  endfunction

  assign req_now   = '{en: enable_req, scale: scale_req, offset: offset_req};
  assign req_d     = req_now;
  assign req_chg   = req_q != req_now;
  assign req_n     = norm(req_q);
  assign vs_d      = pxl_cen ? VS_in : vs_q;
  assign hs_d      = pxl_cen ? HS_in : hs_q;
  assign vs_edge   = pxl_cen & VS_in & ~vs_q;
  assign hs_edge   = pxl_cen & HS_in & ~hs_q;
  assign step_cfg  = step_to(app_q, tgt_q);
  // Switching the scaler off skips the debounce and any slew in progress.
  assign force_off = vs_edge & app_q.en & ~req_n.en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= CFG_OFF;
      app_q   <= CFG_OFF;
      tgt_q   <= CFG_OFF;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      line_q  <= '0;
      fmax_q  <= '0;
      width_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      app_q   <= app_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
      line_q  <= line_d;
      fmax_q  <= fmax_d;
      width_q <= width_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_n != app_q) state_d = HOLD;
      HOLD: begin
        if (req_n == app_q)
          state_d = IDLE;
        else if (vs_edge && !req_chg && cnt_q == HOLD_LAST)
          state_d = STEP;
      end
      STEP: begin
        if (req_n != tgt_q)
          state_d = HOLD;
        else if (vs_edge && step_cfg == tgt_q)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (force_off) state_d = IDLE;
  end

  always_comb begin
    app_d  = app_q;
    tgt_d  = tgt_q;
    busy_d = busy_q;
    cnt_d  = 4'd0;
    case (state_q)
      IDLE: busy_d = req_n != app_q;
      HOLD: begin
        busy_d = req_n != app_q;
        if (!req_chg) cnt_d = vs_edge ? cnt_q + 4'd1 : cnt_q;
        if (state_d == STEP) tgt_d = req_n;
      end
      STEP: begin
        // A changed request freezes the applied values until it is debounced again.
        if (vs_edge && req_n == tgt_q) begin
          app_d  = step_cfg;
          busy_d = step_cfg != tgt_q;
        end
      end
      default: busy_d = 1'b0;
    endcase
    if (force_off) begin
      app_d  = CFG_OFF;
      tgt_d  = CFG_OFF;
      busy_d = 1'b0;
      cnt_d  = 4'd0;
    end
  end

  always_comb begin
    line_d    = line_q;
    fmax_d    = fmax_q;
    width_d   = width_q;
    line_best = (line_q > fmax_q) ? line_q : fmax_q;
    if (hs_edge) begin
      fmax_d = line_best;
      line_d = '0;
    end else if (pxl_cen && !HB_in && line_q != LINE_MAX) begin
      line_d = line_q + VW'(1);
    end
    // The line ending on the vsync pixel still belongs to the frame being reported.
    if (vs_edge) begin
      width_d = hs_edge ? line_best : fmax_q;
      fmax_d  = '0;
    end
  end

  assign scale     = app_q.scale;
  assign offset    = app_q.offset;
  assign enable    = app_q.en;
  assign busy      = busy_q;
  assign act_width = width_q;

endmodule

// File: tb/tb_jtframe_hsize_ctrl.sv
// tb/tb_jtframe_hsize_ctrl.sv - frame-table and width-sequence bench for jtframe_hsize_ctrl
module tb_jtframe_hsize_ctrl;

`ifdef JTFRAME_HSIZE_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, pxl_cen = 1'b0;
  logic       VS_in = 1'b0, HS_in = 1'b0, HB_in = 1'b1;
  logic [3:0] scale_req = 4'd8;
  logic [4:0] offset_req = 5'd0;
  logic       enable_req = 1'b0;
  logic [3:0] scale;
  logic [4:0] offset;
  logic       enable, busy;
  logic [8:0] act_width;

  int total = 0, bad = 0;
  bit cen_div = 1'b0;

  typedef struct {
    logic       er;
    logic [3:0] sr;
    logic [4:0] orq;
    logic       ee;
    logic [3:0] se;
    logic [4:0] oe;
    logic       be;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  jtframe_hsize_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
    .VS_in(VS_in), .HS_in(HS_in), .HB_in(HB_in),
    .scale_req(scale_req), .offset_req(offset_req), .enable_req(enable_req),
    .scale(scale), .offset(offset), .enable(enable), .busy(busy),
    .act_width(act_width)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic er, input logic [3:0] sr, input logic [4:0] orq,
                     input logic ee, input logic [3:0] se, input logic [4:0] oe, input logic be);
    vec_t v;
    v = '{er: er, sr: sr, orq: orq, ee: ee, se: se, oe: oe, be: be};
    tbl.push_back(v);
  endtask

  task automatic pix(input logic hb, input logic hs, input logic vs);
    HB_in = hb; HS_in = hs; VS_in = vs;
    if (cen_div) begin
      pxl_cen = 1'b0;
      @(posedge clk); #1;
    end
    pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
  endtask

  // Three lines, then vertical blanking carrying the VS pulse (or VS rising with the last HS).
  task automatic frame(input int w0, input int w1, input int w2, input bit coincide, input bit nohb);
    int w[3];
    w = '{w0, w1, w2};
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < w[l]; p++) pix(1'b0, 1'b0, 1'b0);
      for (int p = 0; p < 6; p++)
        pix(!nohb, (p >= 2 && p <= 4), (coincide && l == 2 && p >= 2 && p <= 4));
    end
    for (int p = 0; p < 6; p++) pix(!nohb, 1'b0, (!coincide && p >= 2 && p <= 4));
  endtask

  initial begin
    vec_t e;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scale", scale, 8);
    check("rst_offset", offset, 0);
    check("rst_enable", enable, 0);
    check("rst_busy", busy, 0);
    check("rst_width", act_width, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    cen_div = 1'b1;
    frame(320, 330, 320, 1'b0, 1'b0);
    check("width_330", act_width, 330);
    cen_div = 1'b0;
    frame(300, 300, 340, 1'b1, 1'b0);
    check("width_coincide", act_width, 340);
    frame(400, 400, 400, 1'b0, 1'b1);
    check("width_sat", act_width, 383);
    frame(16, 16, 16, 1'b0, 1'b0);

    add(1, 8, 0,       0, 8, 0, 1);
    add(1, 8, 0,       0, 8, 0, 1);
    add(1, 8, 0,       1, 8, 0, 0);
    add(1, 12, 0,      1, 8, 0, 1);
    add(1, 12, 0,      1, 8, 0, 1);
    add(1, 12, 0,      1, SLEW ? 4'd9 : 4'd12, 0, SLEW);
    add(1, 12, 0,      1, SLEW ? 4'd10 : 4'd12, 0, SLEW);
    add(1, 12, 0,      1, SLEW ? 4'd11 : 4'd12, 0, SLEW);
    add(1, 12, 0,      1, 12, 0, 0);
    add(1, 12, 5'h1D,  1, 12, 0, 1);
    add(1, 12, 5'h1D,  1, 12, 0, 1);
    add(1, 12, 5'h1D,  1, 12, SLEW ? 5'h1F : 5'h1D, SLEW);
    add(1, 12, 5'h1D,  1, 12, SLEW ? 5'h1E : 5'h1D, SLEW);
    add(1, 12, 5'h1D,  1, 12, 5'h1D, 0);
    add(1, 12, 2,      1, 12, 5'h1D, 1);
    add(1, 12, 2,      1, 12, 5'h1D, 1);
    add(1, 12, 2,      1, 12, SLEW ? 5'h1E : 5'h02, SLEW);
    add(1, 12, 2,      1, 12, SLEW ? 5'h1F : 5'h02, SLEW);
    add(1, 12, 2,      1, 12, SLEW ? 5'h00 : 5'h02, SLEW);
    add(1, 12, 2,      1, 12, SLEW ? 5'h01 : 5'h02, SLEW);
    add(1, 12, 2,      1, 12, 2, 0);
    add(1, 12, 5,      1, 12, 2, 1);
    add(1, 12, 6,      1, 12, 2, 1);
    add(1, 12, 5,      1, 12, 2, 1);
    add(1, 12, 6,      1, 12, 2, 1);
    add(1, 12, 2,      1, 12, 2, 0);
    add(1, 4, 2,       1, 12, 2, 1);
    add(1, 4, 2,       1, 12, 2, 1);
    add(1, 4, 2,       1, SLEW ? 4'd11 : 4'd4, 2, SLEW);
    add(0, 4, 2,       0, 8, 0, 0);
    add(1, 8, 0,       0, 8, 0, 1);
    add(1, 8, 0,       0, 8, 0, 1);
    add(1, 8, 0,       1, 8, 0, 0);
    add(1, 11, 0,      1, 8, 0, 1);
    add(1, 11, 0,      1, 8, 0, 1);
    add(1, 11, 0,      1, SLEW ? 4'd9 : 4'd11, 0, SLEW);
    add(1, 13, 0,      1, SLEW ? 4'd9 : 4'd11, 0, 1);
    add(1, 13, 0,      1, SLEW ? 4'd9 : 4'd11, 0, 1);
    add(1, 13, 0,      1, SLEW ? 4'd10 : 4'd13, 0, SLEW);
    add(1, 13, 0,      1, SLEW ? 4'd11 : 4'd13, 0, SLEW);

    enable_req = 1'b1; scale_req = 4'd8; offset_req = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("busy_onset", busy, 1);
    check("enable_not_yet", enable, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      enable_req = tbl[i].er; scale_req = tbl[i].sr; offset_req = tbl[i].orq;
      sb.push_back(tbl[i]);
      frame(16, 16, 16, 1'b0, 1'b0);
      if (sb.size() == 0) begin
        check($sformatf("sb_empty[%0d]", i), 0, 1);
      end else begin
        e = sb.pop_front();
        check($sformatf("enable[%0d]", i + 1), enable, e.ee);
        check($sformatf("scale[%0d]", i + 1), scale, e.se);
        check($sformatf("offset[%0d]", i + 1), offset, e.oe);
        check($sformatf("busy[%0d]", i + 1), busy, e.be);
      end
    end
    check("width_16", act_width, 16);

    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_scale", scale, 8);
    check("arst_offset", offset, 0);
    check("arst_enable", enable, 0);
    check("arst_busy", busy, 0);
    check("arst_width", act_width, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
